// File: rtl/sprite_reg_commit_scheduler_if.sv
// Avalon-MM slave bundle for the sprite register commit scheduler.
// chipselect/write/read/address/writedata come from the HPS bridge;
// readdata returns the status word (registered, 1-cycle latency).
interface sprite_reg_commit_scheduler_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              chipselect;
    logic              write;
    logic              read;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic [31:0]       readdata;

    modport slave (
        input  chipselect, write, read, address, writedata,
        output readdata
    );

    modport master (
        output chipselect, write, read, address, writedata,
        input  readdata
    );
endinterface

// File: rtl/sprite_reg_commit_scheduler.sv
// Sprite register commit scheduler.
// Queues CPU register writes and replays them onto the sprite engine's
// register write port only during vertical blank, so every position update
// of a frame lands atomically.
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   bus (slave)       Avalon write path into the FIFO, status readback
//   vcount            VGA line counter; vblank = vcount >= VACTIVE
//   reg_we/addr/data  replayed register writes (addr/data hold when idle)
//   frame_tick        one-cycle pulse the cycle after vblank entry
//   commit_done       one-cycle pulse after a drain empties the FIFO
//   fifo_level        current occupancy
//   overflow          sticky: a write was dropped; cleared by a status write
module sprite_reg_commit_scheduler #(
    parameter int              DEPTH       = 16,
    parameter int              ADDR_W      = 9,
    parameter int              DATA_W      = 32,
    parameter int              VACTIVE     = 480,
    parameter logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(9'h1FF)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    sprite_reg_commit_scheduler_if.slave bus,
    input  logic [9:0]              vcount,
    output logic                    reg_we,
    output logic [ADDR_W-1:0]       reg_addr,
    output logic [DATA_W-1:0]       reg_data,
    output logic                    frame_tick,
    output logic                    commit_done,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [9:0] VACT = 10'(VACTIVE);

    typedef enum logic [1:0] {COLLECT, DRAIN, DONE} state_t;

    state_t state, state_nx;

    logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic vblank, vblank_q, rise;
    logic push_req, push, pop, drop, clear, full;

    assign vblank   = (vcount >= VACT);
    assign rise     = vblank & ~vblank_q;
    assign push_req = bus.chipselect & bus.write & (bus.address != STATUS_ADDR);
    assign clear    = bus.chipselect & bus.write & (bus.address == STATUS_ADDR);
    assign full     = (fifo_level == LW'(DEPTH));
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_comb begin
        state_nx    = state;
        pop         = 1'b0;
        commit_done = 1'b0;
        case (state)
            COLLECT: if (rise) state_nx = DRAIN;
            DRAIN: begin
                if (fifo_level == '0)
                    state_nx = DONE;
                else if (!vblank)
                    state_nx = COLLECT;  // blank ended: leftovers wait for next frame
                else
                    pop = 1'b1;
            end
            DONE: begin
                commit_done = 1'b1;
                state_nx    = COLLECT;
            end
            default: state_nx = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= COLLECT;
            vblank_q     <= 1'b0;
            frame_tick   <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            overflow     <= 1'b0;
            reg_we       <= 1'b0;
            reg_addr     <= '0;
            reg_data     <= '0;
            bus.readdata <= '0;
        end else begin
            state      <= state_nx;
            vblank_q   <= vblank;
            frame_tick <= rise;
            reg_we     <= pop;

            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr               <= rd_ptr + PW'(1);
                {reg_addr, reg_data} <= mem[rd_ptr];
            end

            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase

            if (drop)
                overflow <= 1'b1;
            else if (clear)
                overflow <= 1'b0;

            if (bus.chipselect && bus.read)
                bus.readdata <= {16'h0000, 8'(fifo_level), 6'b000000,
                                 (state == DRAIN), overflow};
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.address, bus.writedata};
    end
endmodule

// File: tb/tb_sprite_reg_commit_scheduler.sv
// Directed bench for sprite_reg_commit_scheduler. Stimulus pushes expected
// strobes, pulses and read data (with their cycle) into queues; a negedge
// monitor pops and compares whenever the DUT presents them.
module tb_sprite_reg_commit_scheduler;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam logic [8:0] STAT = 9'h1FF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [9:0] vcount;
    logic reg_we, frame_tick, commit_done, overflow;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_data;
    logic [4:0] fifo_level;

    sprite_reg_commit_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sprite_reg_commit_scheduler #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .VACTIVE(480), .STATUS_ADDR(STAT)
    ) dut (
        .clk(clk), .reset_n(rst_n), .bus(bus), .vcount(vcount),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data),
        .frame_tick(frame_tick), .commit_done(commit_done),
        .fifo_level(fifo_level), .overflow(overflow)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [8:0] addr; logic [31:0] data; } strobe_t;
    typedef struct { int cyc; logic [31:0] val; } rd_t;
    typedef struct { logic [8:0] addr; logic [31:0] data; } ent_t;

    strobe_t sq[$];
    rd_t     rq[$];
    int      fq[$];
    int      cq[$];
    ent_t    mq[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        strobe_t s;
        rd_t r;
        int c;
        if (reg_we) begin
            if (sq.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_strobe: actual addr %0h data %0h, required no strobe (cycle %0d)",
                         reg_addr, reg_data, cyc);
            end else begin
                s = sq.pop_front();
                chk("strobe_cycle", 64'(cyc), 64'(s.cyc));
                chk("strobe_addr", 64'(reg_addr), 64'(s.addr));
                chk("strobe_data", 64'(reg_data), 64'(s.data));
            end
        end else if (sq.size() != 0 && sq[0].cyc <= cyc) begin
            s = sq.pop_front();
            chk("strobe_missing", 64'(reg_we), 64'd1);
        end

        if (frame_tick) begin
            if (fq.size() == 0) chk("unexpected_frame_tick", 64'(frame_tick), 64'd0);
            else begin c = fq.pop_front(); chk("frame_tick_cycle", 64'(cyc), 64'(c)); end
        end else if (fq.size() != 0 && fq[0] <= cyc) begin
            c = fq.pop_front();
            chk("frame_tick_missing", 64'(frame_tick), 64'd1);
        end

        if (commit_done) begin
            if (cq.size() == 0) chk("unexpected_commit_done", 64'(commit_done), 64'd0);
            else begin c = cq.pop_front(); chk("commit_done_cycle", 64'(cyc), 64'(c)); end
        end else if (cq.size() != 0 && cq[0] <= cyc) begin
            c = cq.pop_front();
            chk("commit_done_missing", 64'(commit_done), 64'd1);
        end

        if (rq.size() != 0 && rq[0].cyc == cyc) begin
            r = rq.pop_front();
            chk("readdata", 64'(bus.readdata), 64'(r.val));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle Avalon write; queued says whether the hand analysis expects it stored.
    task automatic wr(input logic [8:0] a, input logic [31:0] d, input bit queued);
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
        if (queued) mq.push_back('{a, d});
        step(1);
        bus.chipselect = 1'b0; bus.write = 1'b0;
    endtask

    task automatic rd(input logic [31:0] exp);
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = STAT;
        rq.push_back('{cyc + 1, exp});
        step(1);
        bus.chipselect = 1'b0; bus.read = 1'b0;
    endtask

    task automatic vb_start(output int e);
        vcount = 10'd480;
        e = cyc;
        fq.push_back(e + 1);
    endtask

    task automatic expect_drain(input int e, input int n, input bit done);
        ent_t x;
        for (int k = 0; k < n; k++) begin
            x = mq.pop_front();
            sq.push_back('{e + 2 + k, x.addr, x.data});
        end
        if (done) cq.push_back(e + 2 + n);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
        bus.address = '0; bus.writedata = '0;
        vcount = 10'd100;
        step(3);
        chk("rst_reg_we", 64'(reg_we), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_frame_tick", 64'(frame_tick), 64'd0);
        chk("rst_commit_done", 64'(commit_done), 64'd0);
        chk("rst_readdata", 64'(bus.readdata), 64'd0);
        rst_n = 1'b1;
        step(2);

        // Three writes replayed in order in vblank
        wr(9'd0, 32'd120, 1);
        wr(9'd1, 32'd90, 1);
        wr(9'd10, 32'd7, 1);
        chk("t1_level", 64'(fifo_level), 64'd3);
        rd(32'h0000_0300);
        step(5);
        vb_start(e);
        expect_drain(e, 3, 1);
        step(12);
        vcount = 10'd100;
        step(3);
        chk("t1_level_after", 64'(fifo_level), 64'd0);

        // Overflow, status read and clear
        for (int i = 0; i < 17; i++)
            wr(9'(i), 32'h1000 + 32'(i), i < 16);
        chk("t2_level_full", 64'(fifo_level), 64'd16);
        chk("t2_overflow", 64'(overflow), 64'd1);
        rd(32'h0000_1001);
        wr(STAT, 32'd0, 0);
        chk("t2_overflow_clr", 64'(overflow), 64'd0);
        chk("t2_level_kept", 64'(fifo_level), 64'd16);
        rd(32'h0000_1000);
        vb_start(e);
        expect_drain(e, 16, 1);
        step(25);
        vcount = 10'd100;
        step(3);
        chk("t2_level_after", 64'(fifo_level), 64'd0);

        // Full FIFO push concurrent with a drain pop
        for (int i = 0; i < 16; i++)
            wr(9'(32 + i), 32'h2000 + 32'(i), 1);
        vb_start(e);
        step(1);
        wr(9'h055, 32'h0000_ABCD, 1);
        expect_drain(e, 17, 1);
        chk("t3_level", 64'(fifo_level), 64'd16);
        chk("t3_overflow", 64'(overflow), 64'd0);
        step(25);
        vcount = 10'd100;
        step(3);

        // Two-cycle vblank: one strobe, remainder next frame
        for (int i = 0; i < 5; i++)
            wr(9'(64 + i), 32'h3000 + 32'(i), 1);
        vb_start(e);
        expect_drain(e, 1, 0);
        step(2);
        vcount = 10'd100;
        step(5);
        chk("t4_level_left", 64'(fifo_level), 64'd4);
        vb_start(e);
        expect_drain(e, 4, 1);
        step(10);
        vcount = 10'd100;
        step(3);
        chk("t4_level_after", 64'(fifo_level), 64'd0);

        // Empty FIFO at vblank
        vb_start(e);
        expect_drain(e, 0, 1);
        step(6);
        vcount = 10'd100;
        step(3);

        // Reset in the middle of a drain
        for (int i = 0; i < 6; i++)
            wr(9'(96 + i), 32'h4000 + 32'(i), 1);
        vb_start(e);
        expect_drain(e, 1, 0);
        step(3);
        rst_n = 1'b0;
        vcount = 10'd100;
        mq.delete();
        #1;
        chk("t6_reg_we_async", 64'(reg_we), 64'd0);
        chk("t6_level", 64'(fifo_level), 64'd0);
        chk("t6_overflow", 64'(overflow), 64'd0);
        step(2);
        rst_n = 1'b1;
        step(3);
        vb_start(e);
        expect_drain(e, 0, 1);
        step(6);
        vcount = 10'd100;
        step(5);

        chk("strobe_queue_empty", 64'(sq.size()), 64'd0);
        chk("frame_queue_empty", 64'(fq.size()), 64'd0);
        chk("commit_queue_empty", 64'(cq.size()), 64'd0);
        chk("read_queue_empty", 64'(rq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
